// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared state type and constants for the shift sequencer
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic       DIR_LEFT  = 1'b0;
    localparam logic       DIR_RIGHT = 1'b1;
    localparam logic [2:0] MAX_STEP  = 3'd7;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// rtl/shift_sequencer_shifter.sv - 8-bit barrel shifter register with load and fill-bit shifting
module Shifter (
    input  logic       clk,
    input  logic       load,
    input  logic [7:0] in,
    input  logic       rshift,
    input  logic       lshift,
    input  logic [2:0] shiftnum,
    input  logic       inbit,
    output logic [7:0] out
);

    // Vacated bit positions take the value of inbit.
    always_ff @(posedge clk) begin
        if (load) begin
            out <= in;
        end else if (rshift) begin
            out <= (out >> shiftnum) | (inbit ? ~(8'hFF >> shiftnum) : 8'h00);
        end else if (lshift) begin
            out <= (out << shiftnum) | (inbit ? ~(8'hFF << shiftnum) : 8'h00);
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - two-requester round-robin shift command sequencer; SHIFT_SEQ_ROTATE_EN enables rotate mode
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [7:0]       req0_data,
    input  logic             req0_dir,
    input  logic [AMT_W-1:0] req0_amt,
    input  logic             req0_fill,
    input  logic             req0_rot,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [7:0]       req1_data,
    input  logic             req1_dir,
    input  logic [AMT_W-1:0] req1_amt,
    input  logic             req1_fill,
    input  logic             req1_rot,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_id,
    output logic             busy
);

`ifdef SHIFT_SEQ_ROTATE_EN
    localparam logic ROT_EN = 1'b1;
`else
    localparam logic ROT_EN = 1'b0;
`endif

    state_t           state, state_nxt;
    logic             ptr;
    logic             grant0, grant1, gid;
    logic             c_dir, c_fill, c_rot, c_id;
    logic [7:0]       c_data;
    logic [AMT_W-1:0] rem;
    logic [AMT_W-1:0] sel_amt;
    logic             sel_rot;
    logic             rot_mode;
    logic [2:0]       step;
    logic             sh_load, sh_rshift, sh_lshift, sh_inbit;
    logic [2:0]       sh_num;
    logic [7:0]       sh_out;

    // Pointer names the requester that wins when both are valid.
    assign grant0   = req0_valid & (~req1_valid | ~ptr);
    assign grant1   = req1_valid & (~req0_valid | ptr);
    assign gid      = grant1;
    assign sel_amt  = gid ? req1_amt : req0_amt;
    assign sel_rot  = ROT_EN & (gid ? req1_rot : req0_rot);
    assign rot_mode = ROT_EN & c_rot;

    always_comb begin
        step = sh_num_default();
        if (rot_mode) begin
            step = 3'd1;
        end else if (rem > AMT_W'(MAX_STEP)) begin
            step = MAX_STEP;
        end else begin
            step = rem[2:0];
        end
    end

    function automatic logic [2:0] sh_num_default();
        return 3'd0;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= 1'b0;
            c_dir  <= DIR_LEFT;
            c_fill <= 1'b0;
            c_rot  <= 1'b0;
            c_id   <= 1'b0;
            c_data <= 8'h00;
            rem    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (grant0 || grant1)) begin
                c_dir  <= gid ? req1_dir  : req0_dir;
                c_fill <= gid ? req1_fill : req0_fill;
                c_data <= gid ? req1_data : req0_data;
                c_rot  <= sel_rot;
                c_id   <= gid;
                ptr    <= ~gid;
                // Rotation by a multiple of 8 is the identity, so only the low 3 bits count.
                rem    <= sel_rot ? (sel_amt & AMT_W'(3'd7)) : sel_amt;
            end else if (state == SHIFT) begin
                rem <= rem - AMT_W'(step);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        sh_load   = 1'b0;
        sh_rshift = 1'b0;
        sh_lshift = 1'b0;
        sh_num    = 3'd0;
        sh_inbit  = c_fill;
        case (state)
            IDLE: begin
                if (grant0 || grant1) state_nxt = LOAD;
            end
            LOAD: begin
                sh_load   = 1'b1;
                state_nxt = (rem == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                sh_rshift = (c_dir == DIR_RIGHT);
                sh_lshift = (c_dir == DIR_LEFT);
                sh_num    = step;
                if (rot_mode) sh_inbit = (c_dir == DIR_RIGHT) ? sh_out[0] : sh_out[7];
                if (rem == AMT_W'(step)) state_nxt = DONE;
            end
            DONE: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    Shifter u_shifter (
        .clk      (clk),
        .load     (sh_load),
        .in       (c_data),
        .rshift   (sh_rshift),
        .lshift   (sh_lshift),
        .shiftnum (sh_num),
        .inbit    (sh_inbit),
        .out      (sh_out)
    );

    assign req0_ready = (state == IDLE) & grant0;
    assign req1_ready = (state == IDLE) & grant1;
    assign rsp_valid  = (state == DONE);
    assign rsp_data   = (state == DONE) ? sh_out : 8'h00;
    assign rsp_id     = (state == DONE) ? c_id : 1'b0;
    assign busy       = (state != IDLE);

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Command sequencer and two-requester arbiter for the 8-bit barrel shifter datapath. It accepts shift commands (data, direction, amount, fill bit) from two independent requesters and grants one at a time using round-robin arbitration. It drives one internal `Shifter` instance through load and shift steps, splitting amounts larger than 7 into multiple steps, and returns the result on a valid/ready response channel.

## Interface
- `AMT_W`, default 4: command amount width; the maximum amount is 2^AMT_W-1.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req0_valid`  in  1: requester 0 has a command.
- `req0_ready`  out  1: requester 0 command accepted this cycle.
- `req0_data`  in  8: operand.
- `req0_dir`  in  1: 0 = left, 1 = right.
- `req0_amt`  in  AMT_W: shift amount.
- `req0_fill`  in  1: fill bit shifted in.
- `req0_rot`  in  1: rotate mode. Honoured only with the macro.
- `req1_valid`, `req1_ready`, `req1_data`, `req1_dir`, `req1_amt`, `req1_fill`, `req1_rot`: same as the requester 0 ports, for requester 1.
- `rsp_valid`  out  1: result available.
- `rsp_ready`  in  1: consumer accepts the result.
- `rsp_data`  out  8: result.
- `rsp_id`  out  1: index of the requester that issued the command.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- **IDLE**
  - Grant goes to the single valid requester.
  - If both requesters are valid, grant goes to the one selected by the round-robin pointer.
  - `reqN_ready` = (state==IDLE) & grant(N). It is combinational from valid. Requesters must not make valid depend on ready.
  - On handshake: latch dir, amt, fill, rot, data and id; flip the pointer to the other requester; go to LOAD.
- **LOAD**
  - Drive shifter `load=1`, `in`=latched data.
  - Go to DONE if amt==0, otherwise go to SHIFT.
- **SHIFT**
  - Each cycle, step = min(rem, 7).
  - Drive `rshift` (dir=1) or `lshift` (dir=0), with `shiftnum`=step and `inbit`=fill.
  - rem -= step.
  - When rem hits 0, go to DONE.
  - Only one of load/rshift/lshift is ever high. All three are low in IDLE and DONE.
- **DONE**
  - `rsp_valid`=1.
  - `rsp_data` = shifter out.
  - `rsp_id` = latched id.
  - Hold until `rsp_ready`, then go to IDLE.
- `rsp_data` is 0 whenever the state is not DONE.
- Amount ≥ 8 yields all fill bits. The command is still executed in multiple steps; there is no shortcut.
- Reset values: `reqN_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `busy`=0, state=IDLE, pointer prefers requester 0.
- Reset mid-operation drops the in-flight command. No response is produced for it.

## Timing
- Handshake happens in cycle 0.
- LOAD occupies cycle 1.
- SHIFT occupies cycles 2 .. 1+ceil(amt/7).
- `rsp_valid` first rises in cycle 2+ceil(amt/7). Examples: amt=0 → cycle 2; amt=15 → cycle 5.
- Throughput: one command in flight. A new grant is possible no earlier than the cycle after the `rsp_valid`&`rsp_ready` handshake.
- Back-pressure: `rsp_valid`, `rsp_data` and `rsp_id` stay stable while `rsp_ready`=0.
- Round-robin fairness: with both requesters continuously valid, grants alternate 0,1,0,1 starting from requester 0 after reset.

## Configuration
- `SHIFT_SEQ_ROTATE_EN` defined:
  - A command with rot=1 rotates by amt mod 8.
  - It runs amt mod 8 SHIFT cycles, each with shiftnum=1.
  - `inbit` = shifter out[0] for a right rotate, out[7] for a left rotate. Fill is ignored.
  - Rotate amount 0 or 8 goes LOAD→DONE.
- `SHIFT_SEQ_ROTATE_EN` undefined:
  - The `reqN_rot` ports exist but are ignored.
  - All commands are logical shifts with fill.

## Structure
- Package `shift_seq_pkg` holds:
  - the FSM state typedef;
  - constants `DIR_LEFT`=0, `DIR_RIGHT`=1, `MAX_STEP`=7.
- One sub-module: the existing `Shifter`, instantiated once.
  - It has no reset. Its contents are don't-care outside DONE.
- Arbitration, command registers and the FSM live in the top module.

## Test plan
- Req0 0x81, right, amt 3, fill 0 → `req0_ready` in cycle 0; `rsp_valid` in cycle 3 with `rsp_data`=0x10, `rsp_id`=0.
- Req1 0xA5, left, amt 10, fill 1 → two SHIFT cycles (shiftnum 7 then 3); `rsp_data`=0xFF, `rsp_id`=1; `rsp_valid` in cycle 4.
- Both requesters continuously valid, amt 0, `rsp_ready` tied high → grants alternate 0,1,0,1; each response arrives 2 cycles after its grant.
- `rsp_ready` held low for 5 cycles in DONE → `rsp_valid` and `rsp_data` stable; no new grant until the handshake.
- `rst_n` pulsed low during SHIFT of amt 15 → outputs go immediately to 0 and the FSM to IDLE; the next req1 command completes normally.
- With the macro: 0x81, left, rot=1, amt 1 → `rsp_data`=0x03. Without the macro, same command with fill 0 → 0x02.
